rgmii_rx_decode: RTL and testbench

Parametrised RGMII receive decoder placed after the per-pin DDR input capture, in the gmii_rx_clk domain.
- Turns rise/fall sampled nibbles into GMII bytes for 1000 Mb/s, and assembles nibble pairs for 10/100 Mb/s.
- Decodes RX_ER from the RGMII control pair and tracks PHY in-band link status.
- Provides saturating frame and error counters for the MAC and debug UART.

---
 rtl/rgmii_pkg.sv | 32 +++
 rtl/rgmii_rx_decode_if.sv | 22 ++
 rtl/rgmii_inband_status.sv | 51 +++++
 rtl/rgmii_rx_decode.sv | 207 ++++++++++++++++++++
 tb/tb_rgmii_rx_decode.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rgmii_pkg.sv
// Shared constants, types and helpers for the RGMII receive decoder.
// Speed encodings follow the in-band status field layout driven by the PHY.
package rgmii_pkg;

  localparam logic [1:0] SPD_10   = 2'b00;
  localparam logic [1:0] SPD_100  = 2'b01;
  localparam logic [1:0] SPD_1000 = 2'b10;

  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } nib_phase_e;

  localparam int unsigned IB_LINK_BIT = 0;
  localparam int unsigned IB_SPD_LO   = 1;
  localparam int unsigned IB_SPD_HI   = 2;
  localparam int unsigned IB_FDX_BIT  = 3;

  typedef struct packed {
    logic       en;
    logic       dv;
    logic       er;
    logic [7:0] rxd;
    logic       trunc;
  } rx_beat_t;

  // Encoding 2'b11 is reserved and handled as gigabit.
  function automatic logic is_gigabit(input logic [1:0] spd);
    return spd[1];
  endfunction

endpackage

// File: rtl/rgmii_rx_decode_if.sv
// RGMII sampled-pin inputs and GMII byte outputs of the receive decoder.
// master = capture/MAC side, slave = decoder.
interface rgmii_rx_decode_if;
  logic [3:0] rxd_rise;
  logic [3:0] rxd_fall;
  logic       ctl_rise;
  logic       ctl_fall;
  logic       gmii_rx_dv;
  logic       gmii_rx_er;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_en;

  modport master (
    output rxd_rise, rxd_fall, ctl_rise, ctl_fall,
    input  gmii_rx_dv, gmii_rx_er, gmii_rxd, gmii_rx_en
  );

  modport slave (
    input  rxd_rise, rxd_fall, ctl_rise, ctl_fall,
    output gmii_rx_dv, gmii_rx_er, gmii_rxd, gmii_rx_en
  );
endinterface

// File: rtl/rgmii_inband_status.sv
// Glitch-filtered tracker of the PHY in-band link/speed/duplex status sent during idle.
// A value is accepted only after two identical back-to-back qualifying samples.
module rgmii_inband_status
  import rgmii_pkg::*;
(
  input  logic       gmii_rx_clk,
  input  logic       sys_rst_n,
  input  logic       dv,
  input  logic       er,
  input  logic [3:0] rxd_rise,
  output logic       link_up,
  output logic [1:0] link_speed,
  output logic       link_fdx
);

  logic       qual_s;
  logic       match_s;
  logic       have_r;
  logic [3:0] cand_r;
  logic       link_up_r;
  logic [1:0] link_speed_r;
  logic       link_fdx_r;

  assign qual_s  = ~dv & ~er;
  assign match_s = have_r & (rxd_rise == cand_r);

  // Candidate capture and status update; carrier-extend and frame cycles restart the filter.
  always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      have_r       <= 1'b0;
      cand_r       <= 4'h0;
      link_up_r    <= 1'b0;
      link_speed_r <= 2'b00;
      link_fdx_r   <= 1'b0;
    end else if (!qual_s) begin
      have_r <= 1'b0;
    end else if (match_s) begin
      link_up_r    <= rxd_rise[IB_LINK_BIT];
      link_speed_r <= rxd_rise[IB_SPD_HI:IB_SPD_LO];
      link_fdx_r   <= rxd_rise[IB_FDX_BIT];
    end else begin
      cand_r <= rxd_rise;
      have_r <= 1'b1;
    end
  end

  assign link_up    = link_up_r;
  assign link_speed = link_speed_r;
  assign link_fdx   = link_fdx_r;

endmodule

// File: rtl/rgmii_rx_decode.sv
// RGMII receive decoder: DDR nibbles to GMII bytes (1000M) or nibble pairs (10/100),
// RX_ER decode, in-band status and saturating frame/error counters.
module rgmii_rx_decode #(
  parameter int PIPE_STAGES = 1,
  parameter int SPEED_AUTO  = 1,
  parameter int CNT_W       = 16
) (
  input  logic                 gmii_rx_clk,
  input  logic                 sys_rst_n,
  rgmii_rx_decode_if.slave     bus,
  input  logic [1:0]           speed_sel,
  input  logic                 cnt_clr,
  output logic                 link_up,
  output logic [1:0]           link_speed,
  output logic                 link_fdx,
  output logic                 frame_trunc,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic [CNT_W-1:0]     err_frame_cnt
);
  import rgmii_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam int               SLOW_W  = 4 + 2 * CNT_W;

  logic             dv_s;
  logic             er_s;
  logic             dv_g_s;
  logic             blk_s;
  logic             gig_s;
  logic             frame_end_s;
  logic [1:0]       spd_req_s;
  logic             ib_up_s;
  logic [1:0]       ib_speed_s;
  logic             ib_fdx_s;

  logic             armed_r;
  logic [1:0]       spd_r;
  logic             dv_prev_r;
  logic             frm_err_r;
  nib_phase_e       phase_r;
  nib_phase_e       phase_nx_s;
  logic             nib_ld_s;
  logic [3:0]       nib_r;
  logic             nib_er_r;
  rx_beat_t         beat_s;
  rx_beat_t         pipe_r [PIPE_STAGES];

  logic [CNT_W-1:0] frame_cnt_r;
  logic [CNT_W-1:0] err_cnt_r;
  logic [SLOW_W-1:0] slow_s;
  logic [SLOW_W-1:0] slow_q_s;

  assign dv_s = bus.ctl_rise;
  assign er_s = bus.ctl_rise ^ bus.ctl_fall;

  // After reset a frame already in flight is ignored until dv has been seen low.
  assign dv_g_s      = dv_s & armed_r;
  assign blk_s       = dv_s & ~armed_r;
  assign gig_s       = is_gigabit(spd_r);
  assign frame_end_s = dv_prev_r & ~dv_g_s;
  assign spd_req_s   = (SPEED_AUTO != 0) ? ib_speed_s : speed_sel;

  rgmii_inband_status u_inband_status (
    .gmii_rx_clk (gmii_rx_clk),
    .sys_rst_n   (sys_rst_n),
    .dv          (dv_s),
    .er          (er_s),
    .rxd_rise    (bus.rxd_rise),
    .link_up     (ib_up_s),
    .link_speed  (ib_speed_s),
    .link_fdx    (ib_fdx_s)
  );

  // Nibble-phase next state and first-stage output beat.
  always_comb begin
    phase_nx_s = phase_r;
    nib_ld_s   = 1'b0;
    beat_s     = '0;
    if (gig_s) begin
      phase_nx_s = PH_LOW;
      beat_s.en  = 1'b1;
      beat_s.dv  = dv_g_s;
      beat_s.er  = er_s & ~blk_s;
      beat_s.rxd = blk_s ? 8'h00 : {bus.rxd_fall, bus.rxd_rise};
    end else if (dv_g_s) begin
      case (phase_r)
        PH_LOW: begin
          phase_nx_s = PH_HIGH;
          nib_ld_s   = 1'b1;
        end
        PH_HIGH: begin
          phase_nx_s = PH_LOW;
          beat_s.en  = 1'b1;
          beat_s.dv  = 1'b1;
          beat_s.er  = er_s | nib_er_r;
          beat_s.rxd = {bus.rxd_rise, nib_r};
        end
        default: begin
          phase_nx_s = PH_LOW;
        end
      endcase
    end else begin
      phase_nx_s   = PH_LOW;
      beat_s.trunc = (phase_r == PH_HIGH);
    end
  end

  // Nibble-phase state register.
  always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      phase_r <= PH_LOW;
    end else begin
      phase_r <= phase_nx_s;
    end
  end

  // Frame tracking, latched speed and stored low nibble; speed only moves between frames.
  always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      armed_r   <= 1'b0;
      spd_r     <= SPD_10;
      dv_prev_r <= 1'b0;
      frm_err_r <= 1'b0;
      nib_r     <= 4'h0;
      nib_er_r  <= 1'b0;
    end else begin
      armed_r   <= armed_r | ~dv_s;
      dv_prev_r <= dv_g_s;
      frm_err_r <= dv_g_s ? (frm_err_r | er_s) : 1'b0;
      if (!dv_s) begin
        spd_r <= spd_req_s;
      end
      if (nib_ld_s) begin
        nib_r    <= bus.rxd_rise;
        nib_er_r <= er_s;
      end
    end
  end

  // Saturating frame and error-frame counters; clear wins over a coincident frame end.
  always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_cnt_r <= '0;
      err_cnt_r   <= '0;
    end else if (cnt_clr) begin
      frame_cnt_r <= '0;
      err_cnt_r   <= '0;
    end else if (frame_end_s) begin
      if (frame_cnt_r != CNT_MAX) begin
        frame_cnt_r <= frame_cnt_r + CNT_ONE;
      end
      if (frm_err_r && (err_cnt_r != CNT_MAX)) begin
        err_cnt_r <= err_cnt_r + CNT_ONE;
      end
    end
  end

  // Output pipeline for the per-beat GMII signals.
  always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        pipe_r[i] <= '0;
      end
    end else begin
      pipe_r[0] <= beat_s;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign slow_s = {ib_up_s, ib_speed_s, ib_fdx_s, frame_cnt_r, err_cnt_r};

  // Status and counters are already registered once, so they need one stage less.
  generate
    if (PIPE_STAGES > 1) begin : g_slow_dly
      logic [SLOW_W-1:0] dly_r [PIPE_STAGES-1];

      // Extra delay to align status/counters with the data latency.
      always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          for (int i = 0; i < PIPE_STAGES - 1; i++) begin
            dly_r[i] <= '0;
          end
        end else begin
          dly_r[0] <= slow_s;
          for (int i = 1; i < PIPE_STAGES - 1; i++) begin
            dly_r[i] <= dly_r[i-1];
          end
        end
      end

      assign slow_q_s = dly_r[PIPE_STAGES-2];
    end else begin : g_slow_nodly
      assign slow_q_s = slow_s;
    end
  endgenerate

  assign bus.gmii_rx_en = pipe_r[PIPE_STAGES-1].en;
  assign bus.gmii_rx_dv = pipe_r[PIPE_STAGES-1].dv;
  assign bus.gmii_rx_er = pipe_r[PIPE_STAGES-1].er;
  assign bus.gmii_rxd   = pipe_r[PIPE_STAGES-1].rxd;
  assign frame_trunc    = pipe_r[PIPE_STAGES-1].trunc;
  assign {link_up, link_speed, link_fdx, frame_cnt, err_frame_cnt} = slow_q_s;

endmodule

// File: tb/tb_rgmii_rx_decode.sv
// Scoreboard bench for rgmii_rx_decode: directed RGMII vectors push expected GMII bytes,
// an independent negedge monitor pops and compares every strobed byte.
module tb_rgmii_rx_decode;
  import rgmii_pkg::*;

  localparam int PIPE = 2;
  localparam int CW   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    speed_sel;
  logic          cnt_clr;
  logic          link_up;
  logic [1:0]    link_speed;
  logic          link_fdx;
  logic          frame_trunc;
  logic [CW-1:0] frame_cnt;
  logic [CW-1:0] err_frame_cnt;

  always #5 clk = ~clk;

  rgmii_rx_decode_if bus ();

  rgmii_rx_decode #(.PIPE_STAGES(PIPE), .SPEED_AUTO(0), .CNT_W(CW)) dut (
    .gmii_rx_clk   (clk),
    .sys_rst_n     (rst_n),
    .bus           (bus),
    .speed_sel     (speed_sel),
    .cnt_clr       (cnt_clr),
    .link_up       (link_up),
    .link_speed    (link_speed),
    .link_fdx      (link_fdx),
    .frame_trunc   (frame_trunc),
    .frame_cnt     (frame_cnt),
    .err_frame_cnt (err_frame_cnt)
  );

  typedef struct packed {
    logic [7:0] rxd;
    logic       er;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   n_strobe = 0;
  int   n_adj = 0;
  int   n_trunc = 0;
  logic prev_strobe = 1'b0;

  // Monitor: every strobed byte must match the head of the expected queue.
  always @(negedge clk) begin
    if (bus.gmii_rx_en && bus.gmii_rx_dv) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_byte actual rxd=%h er=%b required no byte", bus.gmii_rxd, bus.gmii_rx_er);
      end else begin
        e = exp_q.pop_front();
        if (bus.gmii_rxd !== e.rxd || bus.gmii_rx_er !== e.er) begin
          failures++;
          $display("FAIL byte actual rxd=%h er=%b required rxd=%h er=%b", bus.gmii_rxd, bus.gmii_rx_er, e.rxd, e.er);
        end
      end
      n_strobe++;
      if (prev_strobe) n_adj++;
      prev_strobe = 1'b1;
    end else begin
      prev_strobe = 1'b0;
    end
    if (frame_trunc) n_trunc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drv(input logic [3:0] r, input logic [3:0] f, input logic cr, input logic cf);
    bus.rxd_rise = r;
    bus.rxd_fall = f;
    bus.ctl_rise = cr;
    bus.ctl_fall = cf;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(4'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [7:0] d, input logic er);
    exp_t e;
    e.rxd = d;
    e.er  = er;
    exp_q.push_back(e);
  endtask

  task automatic clr_stats();
    n_strobe = 0;
    n_adj    = 0;
    n_trunc  = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rxd_rise = 4'h0;
    bus.rxd_fall = 4'h0;
    bus.ctl_rise = 1'b0;
    bus.ctl_fall = 1'b0;
    speed_sel    = SPD_1000;
    cnt_clr      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", {31'd0, bus.gmii_rx_en}, 32'd0);
    chk("rst_dv", {31'd0, bus.gmii_rx_dv}, 32'd0);
    chk("rst_rxd", {24'd0, bus.gmii_rxd}, 32'd0);
    chk("rst_link", {28'd0, link_up, link_speed, link_fdx}, 32'd0);
    chk("rst_cnt", {28'd0, frame_cnt, err_frame_cnt}, 32'd0);
    rst_n = 1'b1;
    idle(3);

    // 1000M: 8 bytes of 0xD5
    clr_stats();
    for (int i = 0; i < 8; i++) push(8'hD5, 1'b0);
    for (int i = 0; i < 8; i++) drv(4'h5, 4'hD, 1'b1, 1'b1);
    idle(PIPE + 3);
    chk("g_q_empty", exp_q.size(), 32'd0);
    chk("g_strobes", n_strobe, 32'd8);
    chk("g_adjacent", n_adj, 32'd7);
    chk("g_frame_cnt", {30'd0, frame_cnt}, 32'd1);

    // 100M: 16-nibble preamble/SFD
    speed_sel = SPD_100;
    idle(2);
    clr_stats();
    for (int i = 0; i < 7; i++) push(8'h55, 1'b0);
    push(8'hD5, 1'b0);
    for (int i = 0; i < 15; i++) drv(4'h5, 4'h0, 1'b1, 1'b1);
    drv(4'hD, 4'h0, 1'b1, 1'b1);
    idle(PIPE + 3);
    chk("m_q_empty", exp_q.size(), 32'd0);
    chk("m_strobes", n_strobe, 32'd8);
    chk("m_adjacent", n_adj, 32'd0);
    chk("m_trunc", n_trunc, 32'd0);
    chk("m_frame_cnt", {30'd0, frame_cnt}, 32'd2);

    // 100M: 5-nibble frame, error on first nibble, odd end truncates
    clr_stats();
    push(8'h21, 1'b1);
    push(8'h43, 1'b0);
    drv(4'h1, 4'h0, 1'b1, 1'b0);
    drv(4'h2, 4'h0, 1'b1, 1'b1);
    drv(4'h3, 4'h0, 1'b1, 1'b1);
    drv(4'h4, 4'h0, 1'b1, 1'b1);
    drv(4'h5, 4'h0, 1'b1, 1'b1);
    idle(PIPE + 3);
    chk("t_q_empty", exp_q.size(), 32'd0);
    chk("t_strobes", n_strobe, 32'd2);
    chk("t_trunc", n_trunc, 32'd1);
    chk("t_frame_cnt", {30'd0, frame_cnt}, 32'd3);
    chk("t_err_cnt", {30'd0, err_frame_cnt}, 32'd1);

    // In-band status glitch filter
    drv(4'hD, 4'h0, 1'b0, 1'b0);
    chk("ib_after_d", {28'd0, link_up, link_speed, link_fdx}, 32'd0);
    drv(4'hB, 4'h0, 1'b0, 1'b0);
    chk("ib_after_b1", {28'd0, link_up, link_speed, link_fdx}, 32'd0);
    drv(4'hB, 4'h0, 1'b0, 1'b0);
    chk("ib_after_b2", {28'd0, link_up, link_speed, link_fdx}, 32'd0);
    drv(4'hB, 4'h0, 1'b0, 1'b0);
    chk("ib_up_b", {28'd0, link_up, link_speed, link_fdx}, 32'hB);
    drv(4'h9, 4'h0, 1'b0, 1'b0);
    drv(4'h9, 4'h0, 1'b0, 1'b1);
    drv(4'h9, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < PIPE + 2; i++) drv(4'h9, 4'h0, 1'b0, 1'b1);
    chk("ib_er_resets", {28'd0, link_up, link_speed, link_fdx}, 32'hB);
    drv(4'h9, 4'h0, 1'b0, 1'b0);
    drv(4'h9, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < PIPE + 1; i++) drv(4'h9, 4'h0, 1'b0, 1'b1);
    chk("ib_up_9", {28'd0, link_up, link_speed, link_fdx}, 32'h9);

    // 1000M with one error byte; counters saturate at 3
    speed_sel = SPD_1000;
    idle(2);
    clr_stats();
    push(8'hA1, 1'b0);
    push(8'hB2, 1'b0);
    push(8'hC3, 1'b1);
    push(8'hD4, 1'b0);
    drv(4'h1, 4'hA, 1'b1, 1'b1);
    drv(4'h2, 4'hB, 1'b1, 1'b1);
    drv(4'h3, 4'hC, 1'b1, 1'b0);
    drv(4'h4, 4'hD, 1'b1, 1'b1);
    idle(PIPE + 3);
    chk("e_q_empty", exp_q.size(), 32'd0);
    chk("e_strobes", n_strobe, 32'd4);
    chk("e_frame_cnt_sat", {30'd0, frame_cnt}, 32'd3);
    chk("e_err_cnt", {30'd0, err_frame_cnt}, 32'd2);

    // cnt_clr coincident with a frame end that carries an error
    push(8'hE6, 1'b0);
    push(8'hF7, 1'b1);
    drv(4'h6, 4'hE, 1'b1, 1'b1);
    drv(4'h7, 4'hF, 1'b1, 1'b0);
    cnt_clr = 1'b1;
    drv(4'h0, 4'h0, 1'b0, 1'b0);
    cnt_clr = 1'b0;
    idle(PIPE + 3);
    chk("c_q_empty", exp_q.size(), 32'd0);
    chk("c_frame_cnt", {30'd0, frame_cnt}, 32'd0);
    chk("c_err_cnt", {30'd0, err_frame_cnt}, 32'd0);

    // Reset mid-frame at 100M
    speed_sel = SPD_100;
    idle(2);
    clr_stats();
    drv(4'h5, 4'h0, 1'b1, 1'b1);
    drv(4'h5, 4'h0, 1'b1, 1'b1);
    drv(4'h7, 4'h0, 1'b1, 1'b1);
    chk("r_pre_en", {31'd0, bus.gmii_rx_en}, 32'd1);
    chk("r_pre_rxd", {24'd0, bus.gmii_rxd}, 32'h55);
    rst_n = 1'b0;
    #2;
    chk("r_async_en", {31'd0, bus.gmii_rx_en}, 32'd0);
    chk("r_async_dv", {31'd0, bus.gmii_rx_dv}, 32'd0);
    chk("r_async_rxd", {24'd0, bus.gmii_rxd}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) drv(4'h8, 4'h0, 1'b1, 1'b1);
    idle(1);
    push(8'h76, 1'b0);
    push(8'h98, 1'b0);
    drv(4'h6, 4'h0, 1'b1, 1'b1);
    drv(4'h7, 4'h0, 1'b1, 1'b1);
    drv(4'h8, 4'h0, 1'b1, 1'b1);
    drv(4'h9, 4'h0, 1'b1, 1'b1);
    idle(PIPE + 3);
    chk("r_q_empty", exp_q.size(), 32'd0);
    chk("r_strobes", n_strobe, 32'd2);
    chk("r_trunc", n_trunc, 32'd0);
    chk("r_frame_cnt", {30'd0, frame_cnt}, 32'd1);
    chk("r_err_cnt", {30'd0, err_frame_cnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
